// File: rtl/apb3_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb3_arb_pkg
//   Shared definitions for the two-requester APB3 arbiter in front of the
//   GPIO router.
//   - arb_state_t : FSM encoding (IDLE=0, SETUP=1, ACCESS=2)
//   - ADDR_W_DEF / DATA_W_DEF : default APB address / data widths
//   - WAIT_W : width of the ACCESS wait-state counter
//   - ptr_after() : round-robin pointer value after a completed transfer
// ---------------------------------------------------------------------------
package apb3_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;
   localparam int WAIT_W     = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } arb_state_t;

   // After a completion the preferred requester becomes the one that was
   // not just served: serving m0 (grant 2'b01) prefers m1 next, and
   // serving m1 (grant 2'b10) prefers m0 next.
   function automatic logic ptr_after(input logic [1:0] served);
      return served[0];
   endfunction

endpackage

// File: rtl/apb3_rr_pick.sv
// ---------------------------------------------------------------------------
// apb3_rr_pick
//   Two-way round-robin selector. Purely combinational.
//   Ports:
//     req   [1:0] : request vector, bit N = requester N wants the bus
//     ptr         : preferred requester when both request (0 or 1)
//     grant [1:0] : one-hot winner, 2'b00 when nobody requests
//   A lone requester always wins regardless of ptr.
// ---------------------------------------------------------------------------
module apb3_rr_pick (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/apb3_gpio_arbiter.sv
// ---------------------------------------------------------------------------
// apb3_gpio_arbiter
//   Arbitrates two APB3 requesters (m0 = CPU, m1 = DMA/sequencer) onto one
//   downstream APB3 port feeding the GPIO router.
//
//   Ports:
//     io_apb_PCLK, io_apb_PRESET     : clock, synchronous active-high reset
//     io_m0_apb_* / io_m1_apb_*      : requester-side APB3 completer ports
//     io_apb_P{ADDR,SEL,ENABLE,WRITE,WDATA} : downstream requests (outputs)
//     io_apb_P{READY,RDATA,SLVERROR} : downstream response (inputs)
//     io_grant  [1:0]                : one-hot owner of the current transfer
//     io_dbg_state [1:0]             : FSM state (IDLE/SETUP/ACCESS encoding)
//
//   Handshake: a requester asks for the bus by holding PSEL=1 (PENABLE is
//   ignored). The winner is latched in IDLE, the downstream sees one SETUP
//   cycle and then ACCESS until PREADY=1 or TIMEOUT wait states elapse.
//   The completion cycle raises the granted requester's PREADY
//   combinationally; every other cycle every requester output is 0.
//   The FSM always passes through IDLE between transfers (one bubble).
//
//   Timeout: the wait counter counts ACCESS cycles seen with PREADY=0. The
//   ACCESS cycle in which it reaches TIMEOUT is force-completed with
//   PRDATA=0 and PSLVERROR=1.
// ---------------------------------------------------------------------------
module apb3_gpio_arbiter
   import apb3_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic              io_apb_PCLK,
   input  logic              io_apb_PRESET,

   input  logic [ADDR_W-1:0] io_m0_apb_PADDR,
   input  logic              io_m0_apb_PSEL,
   input  logic              io_m0_apb_PENABLE,
   input  logic              io_m0_apb_PWRITE,
   input  logic [DATA_W-1:0] io_m0_apb_PWDATA,
   output logic              io_m0_apb_PREADY,
   output logic [DATA_W-1:0] io_m0_apb_PRDATA,
   output logic              io_m0_apb_PSLVERROR,

   input  logic [ADDR_W-1:0] io_m1_apb_PADDR,
   input  logic              io_m1_apb_PSEL,
   input  logic              io_m1_apb_PENABLE,
   input  logic              io_m1_apb_PWRITE,
   input  logic [DATA_W-1:0] io_m1_apb_PWDATA,
   output logic              io_m1_apb_PREADY,
   output logic [DATA_W-1:0] io_m1_apb_PRDATA,
   output logic              io_m1_apb_PSLVERROR,

   output logic [ADDR_W-1:0] io_apb_PADDR,
   output logic              io_apb_PSEL,
   output logic              io_apb_PENABLE,
   output logic              io_apb_PWRITE,
   output logic [DATA_W-1:0] io_apb_PWDATA,
   input  logic              io_apb_PREADY,
   input  logic [DATA_W-1:0] io_apb_PRDATA,
   input  logic              io_apb_PSLVERROR,

   output logic [1:0]        io_grant,
   output logic [1:0]        io_dbg_state
);

   // Wait-counter value held at the start of the ACCESS cycle that times out.
   localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 1);

   arb_state_t        state_q,   state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              ptr_q,     ptr_d;
   logic [1:0]        grant_q,   grant_d;
   logic [ADDR_W-1:0] paddr_q,   paddr_d;
   logic              pwrite_q,  pwrite_d;
   logic [DATA_W-1:0] pwdata_q,  pwdata_d;

   logic [1:0]        req;
   logic [1:0]        pick;
   logic              done;
   logic              timeout_hit;

   // PENABLE from the requesters carries no information for arbitration.
   logic              unused_penable;
   assign unused_penable = io_m0_apb_PENABLE ^ io_m1_apb_PENABLE;

   assign req = {io_m1_apb_PSEL, io_m0_apb_PSEL};

   apb3_rr_pick u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick)
   );

   // -------------------------------------------------------------------------
   // Next-state, counter and downstream request registers
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      done        = 1'b0;
      timeout_hit = 1'b0;

      unique case (state_q)
         IDLE: begin
            wait_cnt_d = '0;
            if (|req) begin
               grant_d  = pick;
               paddr_d  = pick[1] ? io_m1_apb_PADDR  : io_m0_apb_PADDR;
               pwrite_d = pick[1] ? io_m1_apb_PWRITE : io_m0_apb_PWRITE;
               pwdata_d = pick[1] ? io_m1_apb_PWDATA : io_m0_apb_PWDATA;
               state_d  = SETUP;
            end
         end

         SETUP: begin
            wait_cnt_d = '0;
            state_d    = ACCESS;
         end

         ACCESS: begin
            if (io_apb_PREADY) begin
               done = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_q == TIMEOUT_LAST) begin
                  done        = 1'b1;
                  timeout_hit = 1'b1;
               end
            end
            if (done) begin
               state_d = IDLE;
               grant_d = 2'b00;
               ptr_d   = ptr_after(grant_q);
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Requester responses: only the granted requester, only in the completion
   // cycle, and only while it still holds PSEL (a dropped request's response
   // is discarded). Reset forces everything to zero.
   // -------------------------------------------------------------------------
   always_comb begin
      io_m0_apb_PREADY    = 1'b0;
      io_m0_apb_PRDATA    = '0;
      io_m0_apb_PSLVERROR = 1'b0;
      io_m1_apb_PREADY    = 1'b0;
      io_m1_apb_PRDATA    = '0;
      io_m1_apb_PSLVERROR = 1'b0;

      if (done && !io_apb_PRESET) begin
         if (grant_q[0] && io_m0_apb_PSEL) begin
            io_m0_apb_PREADY    = 1'b1;
            io_m0_apb_PRDATA    = timeout_hit ? '0 : io_apb_PRDATA;
            io_m0_apb_PSLVERROR = timeout_hit | io_apb_PSLVERROR;
         end
         if (grant_q[1] && io_m1_apb_PSEL) begin
            io_m1_apb_PREADY    = 1'b1;
            io_m1_apb_PRDATA    = timeout_hit ? '0 : io_apb_PRDATA;
            io_m1_apb_PSLVERROR = timeout_hit | io_apb_PSLVERROR;
         end
      end
   end

   always_ff @(posedge io_apb_PCLK) begin
      if (io_apb_PRESET) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         ptr_q      <= 1'b0;
         grant_q    <= 2'b00;
         paddr_q    <= '0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         paddr_q    <= paddr_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
      end
   end

   // Downstream PSEL/PENABLE decode straight from the state register, so
   // they drop on the same edge that returns the FSM to IDLE.
   assign io_apb_PSEL    = (state_q != IDLE);
   assign io_apb_PENABLE = (state_q == ACCESS);
   assign io_apb_PADDR   = paddr_q;
   assign io_apb_PWRITE  = pwrite_q;
   assign io_apb_PWDATA  = pwdata_q;
   assign io_grant       = grant_q;
   assign io_dbg_state   = state_q;

endmodule

// File: doc/apb3_gpio_arbiter.md
APB3_GPIO_ARBITER -- requirements
Module: apb3_gpio_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning APB address width on all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning APB data width on all ports.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles with PREADY low before the transfer is force-completed (range 1..255).
REQ-004 SHALL have port io_apb_PCLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port io_apb_PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports io_m0_apb_PADDR/PSEL/PENABLE/PWRITE/PWDATA, inputs, ADDR_W/1/1/1/DATA_W bits: APB3 requester 0 (CPU).
REQ-007 SHALL have ports io_m0_apb_PREADY/PRDATA/PSLVERROR, outputs, 1/DATA_W/1 bits: requester 0 response.
REQ-008 SHALL have port groups io_m1_apb_*, identical to REQ-006/007: APB3 requester 1 (DMA/sequencer).
REQ-009 SHALL have ports io_apb_PADDR/PSEL/PENABLE/PWRITE/PWDATA, outputs, ADDR_W/1/1/1/DATA_W bits: shared downstream APB3 to the GPIO router.
REQ-010 SHALL have ports io_apb_PREADY/PRDATA/PSLVERROR, inputs, 1/DATA_W/1 bits: downstream response.
REQ-011 SHALL have port io_grant, output, 2 bits: one-hot owner of the current transfer; 2'b00 when idle.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-013 SHALL treat a request from requester N as io_mN_apb_PSEL=1, regardless of PENABLE.
REQ-014 IDLE: with no request, SHALL stay in IDLE; with any request, SHALL latch the winner's PADDR/PWRITE/PWDATA into downstream registers, set io_grant, and go to SETUP.
REQ-015 Arbitration SHALL be round-robin: a priority pointer selects the preferred requester on a tie; after each completion the pointer SHALL move to the other requester; a lone requester always wins.
REQ-016 SETUP: SHALL drive io_apb_PSEL=1 and io_apb_PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-017 ACCESS: SHALL drive io_apb_PSEL=1 and io_apb_PENABLE=1, and increment an 8-bit wait counter each cycle io_apb_PREADY=0.
REQ-018 Completion SHALL occur in ACCESS when io_apb_PREADY=1, or when the wait counter reaches TIMEOUT; the FSM SHALL return to IDLE on the next edge, giving one bubble cycle between transfers.
REQ-019 On completion, the granted requester's PREADY SHALL be 1 combinationally in that cycle, with PRDATA=io_apb_PRDATA and PSLVERROR=io_apb_PSLVERROR.
REQ-020 On a timeout completion, the requester SHALL receive PRDATA=0 and PSLVERROR=1, and io_apb_PSEL SHALL deassert on the next edge.
REQ-021 In every other cycle, each requester's PREADY SHALL be 0; PRDATA SHALL be 0 and PSLVERROR 0.
REQ-022 Minimum latency SHALL be 3 cycles: request seen in IDLE (c0), SETUP (c1), ACCESS with PREADY=1 (c2), requester PREADY=1 in c2.
REQ-023 If the granted requester drops PSEL mid-transfer, the downstream transfer SHALL still run to completion, and its response SHALL be discarded.
REQ-024 A requester's new PSEL asserted in the cycle after its own completion SHALL be arbitrated normally in IDLE.
REQ-025 Downstream PADDR/PWRITE/PWDATA SHALL remain stable from SETUP through completion.

Reset
REQ-026 While io_apb_PRESET=1 at an edge, the block SHALL enter IDLE, clear the wait counter, set the priority pointer to requester 0, and clear io_grant.
REQ-027 Reset SHALL clear io_apb_PSEL, PENABLE, PADDR, PWRITE and PWDATA to 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer without generating a requester PREADY, and downstream PSEL SHALL be 0 after that edge.
REQ-029 All requester response outputs SHALL read 0 while in reset.

Structure
REQ-030 A shared package apb3_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and the ADDR_W/DATA_W defaults.
REQ-031 The round-robin choice SHALL be a sub-module apb3_rr_pick (inputs: req[1:0], pointer; output: one-hot grant); the FSM, counter and muxing SHALL stay in the top module.

Verification
REQ-032 Bench SHALL cover: m0 writes 0x0000_0001 to PADDR 0x0010 with zero wait states -> downstream SETUP at c1, ACCESS at c2, m0 PREADY=1 at c2, m1 PREADY stays 0.
REQ-033 Bench SHALL cover: m0 and m1 request simultaneously after reset -> m0 served first, then m1; with both still requesting, the order alternates m0, m1, m0.
REQ-034 Bench SHALL cover: m1 read of PADDR 0x1008 with downstream PREADY low for 4 cycles and PRDATA=0x0000_A5A5 -> m1 PREADY=1 with PRDATA=0x0000_A5A5 on the 5th ACCESS cycle.
REQ-035 Bench SHALL cover: TIMEOUT=8 with downstream PREADY held 0 -> requester PREADY=1, PSLVERROR=1, PRDATA=0 after 8 ACCESS cycles, then io_apb_PSEL=0.
REQ-036 Bench SHALL cover: io_apb_PRESET pulsed during ACCESS -> io_apb_PSEL=0, io_grant=0, no requester PREADY, and the next request is granted to m0 on a tie.
